romulus_tbc_ctrl: RTL and testbench
===================================

# romulus_tbc_ctrl

Round sequencer for the Romulus TBC datapath. It sits directly upstream of the datapath and drives its register enables, the tweakey mux selects, the counter-correction select and the per-cycle SKINNY round constants. It runs one full SKINNY-128-384+ encryption on request, then one tweakey correction cycle. It also performs standalone block-counter increments. A start/done handshake connects it to the mode-level FSM.

## Interface
Parameters:
- RNDS_PER_CLK, 1, rounds unrolled per clock; NUM_RNDS must be divisible by it.
- NUM_RNDS, 40, total SKINNY rounds per TBC call.
- RC_W, 6, width of one round constant.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request one TBC call; sampled in IDLE only.
- cnt_inc  in  1  request one counter-LFSR step without TBC; sampled in IDLE only.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a TBC call or counter step has completed.
- constant  out  RC_W*RNDS_PER_CLK  round constants; slice i (bits 6i+5:6i) belongs to round r+i of the current cycle.
- sen, senc  out  1 each  state register enable / TBC select.
- xen, xenc  out  1 each  key tweakey (TK3) enable / TBC select.
- yen, yenc  out  1 each  tweak tweakey (TK2) enable / TBC select.
- zen, zenc  out  1 each  counter tweakey (TK1) enable / TBC select.
- correct_cnt  out  1  1 selects the uncorrected counter as LFSR input (pure increment); 0 selects the permutation-corrected counter.

## Operation
- States: IDLE, RUN, CORR, INC, DONE.
- IDLE, start=1: go to RUN. The rc register and the round counter are loaded with 0.
- IDLE, start=0 and cnt_inc=1: go to INC.
- If start and cnt_inc are both high in IDLE, start wins and cnt_inc is dropped.
- start or cnt_inc outside IDLE: ignored. There is no queuing.
- RUN: sen, senc, xen, xenc, yen, yenc, zen and zenc are all 1.
  - The round counter advances by RNDS_PER_CLK each cycle.
  - On the cycle it reaches NUM_RNDS, the next state is CORR.
- CORR: xen, yen and zen are 1. sen, xenc, yenc, zenc and correct_cnt are 0. Next state is DONE.
- INC: zen=1, zenc=0, correct_cnt=1, all other enables 0. Next state is DONE.
- DONE: done=1, all enables 0. Next state is IDLE.
- Round constant LFSR, one step: rc' = {rc[4:0], rc[5]^rc[4]^1'b1}.
  - Slice i of constant = step^(i+1)(rc).
  - In each RUN cycle, rc <= step^RNDS_PER_CLK(rc).
  - constant is forced to 0 outside RUN.
- All outputs decode from registered state only. There is no combinational path from input to output.
- Round counter width is clog2(NUM_RNDS+1). It never wraps, because the exit occurs at NUM_RNDS.

## Timing
- Reset values: state IDLE, rc=0, round counter=0, busy=0, done=0, constant=0, every enable/select=0, correct_cnt=0.
- start sampled high at edge 0 gives this sequence:
  - RUN for cycles 1..NUM_RNDS/RNDS_PER_CLK.
  - CORR on the next cycle.
  - done on the cycle after CORR.
  - With defaults: RUN is cycles 1–40, CORR is cycle 41, done is cycle 42.
- cnt_inc sampled at edge 0 gives INC in cycle 1 and done in cycle 2.
- The earliest next start is accepted in the cycle after done (IDLE). Back-to-back calls therefore repeat every NUM_RNDS/RNDS_PER_CLK+3 cycles.
- rst asserted in any state, including mid-RUN: the next cycle is IDLE with all reset values. No done is issued for the aborted call.

## Structure
- Shared package (romulus_config_pkg): RC_W, NUM_RNDS, RNDS_PER_CLK and the state encoding constants.
- One sub-module, skinny_rc_step: the combinational single LFSR step. It is instantiated RNDS_PER_CLK times in a chain to build both the constant slices and the next rc value.

## Test plan
- Defaults, pulse start: RUN cycles 1–6 give constant 0x01, 0x03, 0x07, 0x0F, 0x1F, 0x3E. Cycle 40 gives 0x1A. CORR is cycle 41 with xen=yen=zen=1 and senc=0. done is a single pulse at cycle 42. busy is high for cycles 1–42.
- RNDS_PER_CLK=4: the first RUN cycle gives constant = {0x0F, 0x07, 0x03, 0x01} (MSB slice first). There are 10 RUN cycles, and done comes at cycle 12.
- Pulse cnt_inc in IDLE: cycle 1 has zen=1, zenc=0, correct_cnt=1 and sen=xen=yen=0. done comes at cycle 2.
- start and cnt_inc high together: a full TBC sequence runs and no INC cycle ever appears. A start pulse during RUN is ignored, leaving a single done.
- rst at RUN cycle 20: the next cycle is IDLE with every output 0. A new start then restarts the constants at 0x01.
- Back-to-back: start held high continuously gives done pulses at cycles 42, 85 and 128, with no CORR skipped.

Source files
------------

// File: rtl/romulus_config_pkg.sv
// ============================================================================
// Module  : romulus_config_pkg
// Brief   : Shared configuration and state encoding for the Romulus TBC
//           round sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package romulus_config_pkg;

    localparam int RC_W         = 6;
    localparam int NUM_RNDS     = 40;
    localparam int RNDS_PER_CLK = 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_CORR = 3'd2,
        ST_INC  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/skinny_rc_step.sv
// ============================================================================
// Module  : skinny_rc_step
// Brief   : One combinational step of the SKINNY round-constant LFSR.
// Revision: 1.0
// ============================================================================
`default_nettype none

module skinny_rc_step #(
    parameter int RC_W = 6
) (
    input  logic [RC_W-1:0] rc_i,
    output logic [RC_W-1:0] rc_o
);

    assign rc_o = {rc_i[RC_W-2:0], rc_i[RC_W-1] ^ rc_i[RC_W-2] ^ 1'b1};

endmodule

`default_nettype wire

// File: rtl/romulus_tbc_ctrl.sv
// ============================================================================
// Module  : romulus_tbc_ctrl
// Brief   : Round sequencer driving the Romulus TBC datapath enables, tweakey
//           selects, counter correction select and SKINNY round constants.
// Revision: 1.0
// ============================================================================
`default_nettype none

module romulus_tbc_ctrl #(
    parameter int RNDS_PER_CLK = romulus_config_pkg::RNDS_PER_CLK,
    parameter int NUM_RNDS     = romulus_config_pkg::NUM_RNDS,
    parameter int RC_W         = romulus_config_pkg::RC_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         cnt_inc,
    output logic                         busy,
    output logic                         done,
    output logic [RC_W*RNDS_PER_CLK-1:0] constant,
    output logic                         sen,
    output logic                         senc,
    output logic                         xen,
    output logic                         xenc,
    output logic                         yen,
    output logic                         yenc,
    output logic                         zen,
    output logic                         zenc,
    output logic                         correct_cnt
);

    import romulus_config_pkg::*;

    localparam int              CNT_W    = $clog2(NUM_RNDS + 1);
    localparam logic [CNT_W-1:0] RND_STEP = CNT_W'(RNDS_PER_CLK);
    localparam logic [CNT_W-1:0] RND_LAST = CNT_W'(NUM_RNDS);

    state_e                          state_q, state_d;
    logic [RC_W-1:0]                 rc_q, rc_d;
    logic [CNT_W-1:0]                rnd_q, rnd_d;
    logic [RC_W*RNDS_PER_CLK-1:0]    rc_slices;

    // Chained LFSR steps: slice i is rc advanced i+1 times; the last slice
    // is also the rc value for the next cycle.
    generate
        for (genvar i = 0; i < RNDS_PER_CLK; i++) begin : g_rc_chain
            logic [RC_W-1:0] rc_in;
            logic [RC_W-1:0] rc_out;
            if (i == 0) begin : g_first
                assign rc_in = rc_q;
            end else begin : g_next
                assign rc_in = g_rc_chain[i-1].rc_out;
            end
            skinny_rc_step #(.RC_W(RC_W)) u_step (
                .rc_i (rc_in),
                .rc_o (rc_out)
            );
            assign rc_slices[i*RC_W +: RC_W] = rc_out;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rc_q    <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rc_d        = rc_q;
        rnd_d       = rnd_q;
        busy        = 1'b0;
        done        = 1'b0;
        constant    = '0;
        sen         = 1'b0;
        senc        = 1'b0;
        xen         = 1'b0;
        xenc        = 1'b0;
        yen         = 1'b0;
        yenc        = 1'b0;
        zen         = 1'b0;
        zenc        = 1'b0;
        correct_cnt = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    rc_d    = '0;
                    rnd_d   = '0;
                end else if (cnt_inc) begin
                    state_d = ST_INC;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                sen      = 1'b1;
                senc     = 1'b1;
                xen      = 1'b1;
                xenc     = 1'b1;
                yen      = 1'b1;
                yenc     = 1'b1;
                zen      = 1'b1;
                zenc     = 1'b1;
                constant = rc_slices;
                rc_d     = rc_slices[(RNDS_PER_CLK-1)*RC_W +: RC_W];
                rnd_d    = rnd_q + RND_STEP;
                if (rnd_d == RND_LAST) begin
                    state_d = ST_CORR;
                end
            end
            ST_CORR: begin
                busy    = 1'b1;
                xen     = 1'b1;
                yen     = 1'b1;
                zen     = 1'b1;
                state_d = ST_DONE;
            end
            ST_INC: begin
                busy        = 1'b1;
                zen         = 1'b1;
                correct_cnt = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_romulus_tbc_ctrl.sv
// ============================================================================
// Module  : tb_romulus_tbc_ctrl
// Brief   : Self-checking bench for romulus_tbc_ctrl at 1 and 4 rounds/clock.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_romulus_tbc_ctrl;

    localparam int NR = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cnt_inc = 1'b0;

    logic        busy1, done1, sen1, senc1, xen1, xenc1, yen1, yenc1, zen1, zenc1, cc1;
    logic [5:0]  const1;
    logic        busy4, done4, sen4, senc4, xen4, xenc4, yen4, yenc4, zen4, zenc4, cc4;
    logic [23:0] const4;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;

    // Model: transaction kind (0 idle, 1 TBC, 2 counter step) and cycle index within it
    int m1k = 0, m1c = 0;
    int m4k = 0, m4c = 0;

    logic [5:0] rcseq [0:NR];
    logic [5:0] lit   [0:5];

    always #5 clk = ~clk;

    romulus_tbc_ctrl dut1 (
        .clk(clk), .rst(rst), .start(start), .cnt_inc(cnt_inc),
        .busy(busy1), .done(done1), .constant(const1),
        .sen(sen1), .senc(senc1), .xen(xen1), .xenc(xenc1),
        .yen(yen1), .yenc(yenc1), .zen(zen1), .zenc(zenc1),
        .correct_cnt(cc1)
    );

    romulus_tbc_ctrl #(.RNDS_PER_CLK(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .cnt_inc(cnt_inc),
        .busy(busy4), .done(done4), .constant(const4),
        .sen(sen4), .senc(senc4), .xen(xen4), .xenc(xenc4),
        .yen(yen4), .yenc(yenc4), .zen(zen4), .zenc(zenc4),
        .correct_cnt(cc4)
    );

    // Flag order: {busy, done, sen, senc, xen, xenc, yen, yenc, zen, zenc, correct_cnt}
    function automatic logic [10:0] exp_flags(int k, int c, int r);
        if (k == 1) begin
            if (c <= NR / r)      return 11'b10111111110;
            if (c == NR / r + 1)  return 11'b10001010100;
            return 11'b11000000000;
        end
        if (k == 2) begin
            if (c == 1) return 11'b10000000101;
            return 11'b11000000000;
        end
        return 11'b00000000000;
    endfunction

    function automatic logic [23:0] exp_const(int k, int c, int r);
        logic [23:0] v = '0;
        if (k == 1 && c <= NR / r) begin
            for (int i = 0; i < r; i++) v[i*6 +: 6] = rcseq[(c-1)*r + i + 1];
        end
        return v;
    endfunction

    task automatic adv(inout int k, inout int c, input int r, input bit s, input bit ci, input bit rs);
        int len;
        len = (k == 1) ? NR / r + 2 : 2;
        if (rs) begin
            k = 0; c = 0;
        end else if (k == 0) begin
            if (s)       begin k = 1; c = 1; end
            else if (ci) begin k = 2; c = 1; end
        end else if (c == len) begin
            k = 0; c = 0;
        end else begin
            c = c + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc_no, obs, exp);
        end
    endtask

    task automatic step(input bit s, input bit ci, input bit rs);
        start   = s;
        cnt_inc = ci;
        rst     = rs;
        @(posedge clk);
        adv(m1k, m1c, 1, s, ci, rs);
        adv(m4k, m4c, 4, s, ci, rs);
        cyc_no++;
        @(negedge clk);
        chk("flags_r1", 24'({busy1, done1, sen1, senc1, xen1, xenc1, yen1, yenc1, zen1, zenc1, cc1}),
            24'(exp_flags(m1k, m1c, 1)));
        chk("const_r1", 24'(const1), exp_const(m1k, m1c, 1));
        chk("flags_r4", 24'({busy4, done4, sen4, senc4, xen4, xenc4, yen4, yenc4, zen4, zenc4, cc4}),
            24'(exp_flags(m4k, m4c, 4)));
        chk("const_r4", const4, exp_const(m4k, m4c, 4));
    endtask

    initial begin
        int b2b_dones;
        rcseq[0] = 6'd0;
        for (int k = 1; k <= NR; k++) begin
            rcseq[k] = 6'(((rcseq[k-1] << 1) & 6'h3F) | ((rcseq[k-1] >> 5) ^ (rcseq[k-1] >> 4) ^ 6'd1) & 6'd1);
        end
        lit[0] = 6'h01; lit[1] = 6'h03; lit[2] = 6'h07;
        lit[3] = 6'h0F; lit[4] = 6'h1F; lit[5] = 6'h3E;

        // Reset state, then idle
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);

        // Single TBC call with known constant values
        for (int c = 1; c <= 44; c++) begin
            step(c == 1, 0, 0);
            if (c <= 6)  chk("const_lit", 24'(const1), 24'(lit[c-1]));
            if (c == 40) chk("const_c40", 24'(const1), 24'h00001A);
            if (c == 1)  chk("const4_c1", const4, 24'h3C70C1);
        end

        // Standalone counter step
        step(0, 1, 0);
        for (int c = 0; c < 3; c++) step(0, 0, 0);

        // start and cnt_inc together, plus a start pulse mid-RUN
        step(1, 1, 0);
        for (int c = 2; c <= 46; c++) step(c == 10, c == 11, 0);

        // Reset at RUN cycle 20, then restart
        step(1, 0, 0);
        for (int c = 2; c <= 20; c++) step(0, 0, 0);
        step(0, 0, 1);
        step(1, 0, 0);
        chk("restart_const", 24'(const1), 24'h000001);
        for (int c = 0; c < 44; c++) step(0, 0, 0);

        // Back-to-back with start held high
        b2b_dones = 0;
        for (int c = 1; c <= 130; c++) begin
            step(1, 0, 0);
            if (done1 === 1'b1) b2b_dones++;
        end
        chk("b2b_done_count", 24'(b2b_dones), 24'd3);
        for (int c = 0; c < 50; c++) step(0, 0, 0);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
